// File: rtl/id_imm_ctrl_pkg.sv
// Shared decode constants for the decode-stage immediate controller.
// Opcode map, ExtOp codes, buffer state encoding and the decoded-entry width.
package id_imm_ctrl_pkg;

   localparam int XLEN_DEF    = 64;
   localparam int INST_DW_DEF = 32;

   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;

   localparam logic [2:0] EXT_I = 3'b000;
   localparam logic [2:0] EXT_U = 3'b001;
   localparam logic [2:0] EXT_S = 3'b010;
   localparam logic [2:0] EXT_B = 3'b011;
   localparam logic [2:0] EXT_J = 3'b100;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_e;

   // Entry layout, MSB first: instr, pc, imm, extop[2:0], has_imm, illegal.
   function automatic int entry_width(input int xlen, input int inst_dw);
      return inst_dw + 2 * xlen + 3 + 1 + 1;
   endfunction

   localparam int ENTRY_W = entry_width(XLEN_DEF, INST_DW_DEF);

endpackage

// File: rtl/id_imm_ctrl_imm_gen_core.sv
// Combinational immediate former: picks and sign-extends the instr[31:7] fields by ExtOp.
// Zero latency; reserved ExtOp codes produce a zero immediate.
module imm_gen_core
   import id_imm_ctrl_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      extop,
   input  logic [31:7]     instr_hi,
   output logic [XLEN-1:0] imm
);

   always_comb begin
      imm = '0;
      case (extop)
         EXT_I: imm = {{(XLEN-12){instr_hi[31]}}, instr_hi[31:20]};
         EXT_U: imm = {{(XLEN-32){instr_hi[31]}}, instr_hi[31:12], 12'b0};
         EXT_S: imm = {{(XLEN-12){instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
         EXT_B: imm = {{(XLEN-13){instr_hi[31]}}, instr_hi[31], instr_hi[7],
                       instr_hi[30:25], instr_hi[11:8], 1'b0};
         EXT_J: imm = {{(XLEN-21){instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                       instr_hi[20], instr_hi[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/id_imm_ctrl.sv
// Decode-stage controller: classifies the opcode, forms the immediate and buffers the entry
// in a main+skid pair; one-cycle latency, full throughput, in_ready drops only when skid is full.
module id_imm_ctrl
   import id_imm_ctrl_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int INST_DW = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INST_DW-1:0] in_instr,
   input  logic [XLEN-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INST_DW-1:0] out_instr,
   output logic [XLEN-1:0]    out_pc,
   output logic [XLEN-1:0]    out_imm,
   output logic [2:0]         out_extop,
   output logic               out_has_imm,
   output logic               out_illegal
);

   localparam int EW = entry_width(XLEN, INST_DW);

   logic [2:0]      dec_extop;
   logic            dec_has_imm;
   logic            dec_illegal;
   logic [XLEN-1:0] gen_imm;
   logic [XLEN-1:0] dec_imm;
   logic [EW-1:0]   new_entry;

   buf_state_e      state_q, state_d;
   logic [EW-1:0]   main_q, main_d;
   logic [EW-1:0]   skid_q, skid_d;
   logic            accept;
   logic            consume;

   always_comb begin
      dec_extop   = EXT_I;
      dec_has_imm = 1'b1;
      dec_illegal = 1'b0;
      case (in_instr[6:0])
         OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM: dec_extop = EXT_I;
         OPC_LUI, OPC_AUIPC: dec_extop = EXT_U;
         OPC_STORE:          dec_extop = EXT_S;
         OPC_BRANCH:         dec_extop = EXT_B;
         OPC_JAL:            dec_extop = EXT_J;
         OPC_OP, OPC_OP32:   dec_has_imm = 1'b0;
         default: begin
            dec_has_imm = 1'b0;
            dec_illegal = 1'b1;
         end
      endcase
   end

   imm_gen_core #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .extop    (dec_extop),
      .instr_hi (in_instr[31:7]),
      .imm      (gen_imm)
   );

   // Register-register and unknown opcodes report EXT_I, so the raw I-field must be masked.
   assign dec_imm   = dec_has_imm ? gen_imm : '0;
   assign new_entry = {in_instr, in_pc, dec_imm, dec_extop, dec_has_imm, dec_illegal};

   assign in_ready  = (state_q != ST_FULL) && !flush;
   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready && !flush;

   assign {out_instr, out_pc, out_imm, out_extop, out_has_imm, out_illegal} = main_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_d  = new_entry;
                  state_d = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (accept && !consume) begin
                  skid_d  = new_entry;
                  state_d = ST_FULL;
               end else if (accept && consume) begin
                  main_d  = new_entry;
               end else if (consume) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (consume) begin
                  main_d  = skid_q;
                  state_d = ST_BUSY;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: doc/id_imm_ctrl.md
Name: id_imm_ctrl

Overview:
- Decode-stage controller that sequences the immediate generator between IFU and EXU.
- Accepts a fetched instruction and PC over valid/ready, classifies the opcode into an ExtOp select, and drives an internal immediate generator.
- Registers the instruction, PC, immediate and class flags into a 2-entry skid buffer, so full throughput is sustained under EXU back-pressure.
- Supports pipeline flush from branch/jump redirect.

Parameters:
- XLEN, 64, datapath width; immediates are sign-extended to XLEN.
- INST_DW, 32, instruction width.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  IFU presents an instruction
- in_ready  output  1  block accepts the instruction this cycle
- in_instr  input  INST_DW  fetched instruction
- in_pc  input  XLEN  PC of in_instr
- flush  input  1  discard all buffered and incoming instructions
- out_valid  output  1  decoded entry available to EXU
- out_ready  input  1  EXU consumes the entry
- out_instr  output  INST_DW  registered instruction
- out_pc  output  XLEN  registered PC
- out_imm  output  XLEN  sign-extended immediate
- out_extop  output  3  immediate class: 000 I, 001 U, 010 S, 011 B, 100 J
- out_has_imm  output  1  instruction uses an immediate
- out_illegal  output  1  opcode not recognised

Behaviour:
- Interface (already decided): one clock, clk; rst is synchronous and active-high.
- Opcode decode on in_instr[6:0]; combinational, evaluated only at the accept edge:
  - 0000011, 0010011, 0011011, 1100111, 1110011 -> extop 000, has_imm 1.
  - 0110111, 0010111 -> extop 001, has_imm 1.
  - 0100011 -> extop 010, has_imm 1.
  - 1100011 -> extop 011, has_imm 1.
  - 1101111 -> extop 100, has_imm 1.
  - 0110011, 0111011 -> extop 000, has_imm 0, imm forced to 0.
  - Any other opcode -> extop 000, has_imm 0, imm 0, illegal 1.
- Immediate formation, from instr[31:7], sign-extended from instr[31]:
  - I: instr[31:20].
  - U: instr[31:12] followed by 12 zeros, sign-extended above bit 31.
  - S: instr[31:25], then instr[11:7].
  - B: instr[31], instr[7], instr[30:25], instr[11:8], 0.
  - J: instr[31], instr[19:12], instr[20], instr[30:21], 0.
  - ExtOp values 101–111 never leave the block and yield imm 0.
- Buffer: a main register plus one skid register, each holding the full decoded entry and a valid bit.
- State machine (derived from the valid bits):
  - EMPTY: out_valid 0. Accept -> BUSY.
  - BUSY: out_valid 1, main drives the outputs.
    - Accept with no consume -> FULL (new entry goes to skid).
    - Accept with consume -> BUSY (new entry goes to main).
    - Consume with no accept -> EMPTY.
  - FULL: out_valid 1, in_ready 0. Consume -> BUSY (skid moves to main in the same edge).
- in_ready = !skid_valid && !flush. It is registered-derived only: no combinational path from out_ready to in_ready.
- Accept = in_valid && in_ready; consume = out_valid && out_ready.
- Latency: an instruction accepted at edge N is on out_* after edge N (visible in cycle N+1) when the buffer was EMPTY.
- Output order equals accept order; no entry is ever duplicated or dropped except by flush.
- Flush: at the edge where flush=1, both valid bits clear and the state goes to EMPTY. in_ready is 0 that cycle, so the input is not accepted. A flush with out_ready=1 still counts as no consume.
- Reset: all valid bits 0, out_valid 0, in_ready 1 the cycle after reset deasserts. out_instr, out_pc, out_imm, out_extop, out_has_imm and out_illegal are 0.
- Reset mid-operation discards all entries, identical to flush.
- Data registers load only on accept or skid-to-main move; they hold when idle.

Decomposition:
- Shared package holds:
  - Opcode constants (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM, OPC_LUI, OPC_AUIPC, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_OP, OPC_OP32).
  - ExtOp constants EXT_I/U/S/B/J.
  - The decoded-entry bundle width.
- One sub-module: imm_gen_core, the combinational immediate former keyed by ExtOp, instantiated once ahead of the buffer.

Test Plan:
- Reset, then in_instr=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, extop 000, imm 0x5, has_imm 1.
- Back-to-back stream:
  - Inputs: 0xFFF00093 (addi -1), 0x800000B7 (lui), 0xFE112E23 (sw x1,-4(x2)), 0xFE0008E3 (beq -16), 0x8000006F (jal).
  - out_ready=1 -> one output per cycle, in order.
  - Expected imm: 0xFFFF_FFFF_FFFF_FFFF, 0xFFFF_FFFF_8000_0000, 0xFFFF_FFFF_FFFF_FFFC, 0xFFFF_FFFF_FFFF_FFF0, 0xFFFF_FFFF_FFF0_0000.
- Back-pressure: out_ready=0 while sending 3 instructions -> first two accepted, in_ready=0 on the third. Raise out_ready -> all three emerge in order, none lost.
- Classification: 0x002081B3 (add) -> has_imm 0, imm 0, illegal 0. Opcode 0x7F -> illegal 1, extop 000.
- Flush in FULL state with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed and incoming instructions never appear.
- Reset asserted while FULL -> next cycle all outputs 0 and in_ready=1; the first post-reset instruction emerges with latency 1.
